// File: rtl/i2s_mic_array_sequencer.sv
// I2S bit/word clock master for a bank of receivers. It snapshots every receiver
// once per ws frame and serialises the snapshot onto an AXI4-Stream master.
`timescale 1ns/1ps
module i2s_mic_array_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_MICS      = 4,
    parameter int SCK_DIV       = 8,
    parameter int SLOT_BITS     = 32,
    parameter int CAPTURE_DELAY = 4
) (
    input  logic                           M_AXIS_ACLK,
    input  logic                           M_AXIS_ARESETN,
    input  logic                           enable,
    output logic                           sck,
    output logic                           ws,
    input  logic [NUM_MICS*DATA_WIDTH-1:0] mic_left,
    input  logic [NUM_MICS*DATA_WIDTH-1:0] mic_right,
    output logic                           M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0]          M_AXIS_TDATA,
    output logic                           M_AXIS_TLAST,
    input  logic                           M_AXIS_TREADY,
    output logic                           overrun,
    output logic [15:0]                    frame_count
);
    localparam int NUM_WORDS = 2 * NUM_MICS;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam int DIV_W     = $clog2(SCK_DIV);
    localparam int BIT_W     = $clog2(SLOT_BITS);
    localparam int RISE_W    = $clog2(CAPTURE_DELAY);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_BITS - 1);
    localparam logic [RISE_W-1:0] RISE_LAST = RISE_W'(CAPTURE_DELAY - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [0:0] {
        ST_WAIT,
        ST_SEND
    } state_t;

    state_t                          state;
    state_t                          next_state;
    logic [DIV_W-1:0]                div_cnt;
    logic [BIT_W-1:0]                bit_cnt;
    logic [RISE_W-1:0]               rise_cnt;
    logic                            armed;
    logic                            enable_q;
    logic [IDX_W-1:0]                index;
    logic [NUM_WORDS*DATA_WIDTH-1:0] snap;
    logic [NUM_WORDS*DATA_WIDTH-1:0] frame_words;

    logic div_tc;
    logic rise_evt;
    logic fall_evt;
    logic slot_end;
    logic capture_pt;
    logic sending;
    logic beat;
    logic last_word;

    assign div_tc     = enable && (div_cnt == DIV_LAST);
    assign rise_evt   = div_tc && !sck;
    assign fall_evt   = div_tc && sck;
    assign slot_end   = fall_evt && (bit_cnt == BIT_LAST);
    assign capture_pt = rise_evt && armed && (rise_cnt == RISE_LAST);
    assign sending    = (state == ST_SEND);
    assign beat       = sending && M_AXIS_TREADY;
    assign last_word  = (index == IDX_LAST);

    // Dropping enable parks sck/ws low regardless of phase, so a restart is always clean.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
            ws      <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
            ws      <= 1'b0;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                sck     <= ~sck;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_evt) begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt <= '0;
                    ws      <= ~ws;
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
        end
    end

    // Arms only on a ws 1->0 edge, so the first left slot after enable never captures.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            armed    <= 1'b0;
            rise_cnt <= '0;
        end else if (!enable) begin
            armed    <= 1'b0;
            rise_cnt <= '0;
        end else if (slot_end && ws) begin
            armed    <= 1'b1;
            rise_cnt <= '0;
        end else if (capture_pt) begin
            armed    <= 1'b0;
        end else if (rise_evt && armed) begin
            rise_cnt <= rise_cnt + RISE_W'(1);
        end
    end

    always_comb begin
        frame_words = '0;
        for (int k = 0; k < NUM_MICS; k++) begin
            frame_words[(2*k)*DATA_WIDTH +: DATA_WIDTH]   = mic_left[k*DATA_WIDTH +: DATA_WIDTH];
            frame_words[(2*k+1)*DATA_WIDTH +: DATA_WIDTH] = mic_right[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state <= ST_WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TLAST  = 1'b0;
        case (state)
            ST_WAIT: begin
                if (capture_pt) begin
                    next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = snap[int'(index)*DATA_WIDTH +: DATA_WIDTH];
                M_AXIS_TLAST  = last_word;
                if (beat && last_word) begin
                    next_state = ST_WAIT;
                end
            end
            default: next_state = ST_WAIT;
        endcase
    end

    // The snapshot is only written from WAIT; a capture point during SEND leaves it intact.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            snap        <= '0;
            index       <= '0;
            frame_count <= '0;
        end else if (state == ST_WAIT) begin
            if (capture_pt) begin
                snap  <= frame_words;
                index <= '0;
            end
        end else if (beat) begin
            if (last_word) begin
                index       <= '0;
                frame_count <= frame_count + 16'd1;
            end else begin
                index <= index + IDX_W'(1);
            end
        end
    end

    // Set has priority over the enable-rise clear.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            enable_q <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            enable_q <= enable;
            if (sending && capture_pt) begin
                overrun <= 1'b1;
            end else if (enable && !enable_q) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_mic_array_sequencer.sv
// Self-checking bench for i2s_mic_array_sequencer: fixed vector tables, directed
// corner-case sequences and a randomized run against a frame-level reference model.
`timescale 1ns/1ps
module tb_i2s_mic_array_sequencer;
    localparam int DW = 32;
    localparam int NM = 2;
    localparam int SD = 2;
    localparam int SB = 32;
    localparam int CD = 4;
    localparam int FRAME_PERIOD = 4 * SD * SB;
    localparam int CAP_OFFSET   = SD * (2 * CD - 1);
    localparam int FIRST_CAP    = FRAME_PERIOD + CAP_OFFSET;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               sck;
    logic               ws;
    logic [NM*DW-1:0]   mic_left;
    logic [NM*DW-1:0]   mic_right;
    logic               tvalid;
    logic [DW-1:0]      tdata;
    logic               tlast;
    logic               tready;
    logic               overrun;
    logic [15:0]        frame_count;

    i2s_mic_array_sequencer #(
        .DATA_WIDTH(DW), .NUM_MICS(NM), .SCK_DIV(SD), .SLOT_BITS(SB), .CAPTURE_DELAY(CD)
    ) dut (
        .M_AXIS_ACLK(clk),
        .M_AXIS_ARESETN(rst_n),
        .enable(enable),
        .sck(sck),
        .ws(ws),
        .mic_left(mic_left),
        .mic_right(mic_right),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TDATA(tdata),
        .M_AXIS_TLAST(tlast),
        .M_AXIS_TREADY(tready),
        .overrun(overrun),
        .frame_count(frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame-level reference: enabled-edge count n gives sck/ws/capture by arithmetic,
    // the pending frame is a queue of words still to be sent.
    int          n;
    logic        en_prev;
    logic [31:0] q[$];
    logic        m_overrun;
    logic [15:0] m_fcount;

    int compared;
    int mismatched;

    typedef struct {
        logic        tready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] exp_frame[4];

    task automatic modelReset();
        n         = 0;
        en_prev   = 1'b0;
        q.delete();
        m_overrun = 1'b0;
        m_fcount  = 16'd0;
    endtask

    task automatic modelEdge();
        logic busy;
        logic cap;
        int   nn;
        if (!rst_n) begin
            modelReset();
        end else begin
            busy = (q.size() > 0);
            if (busy && tready) begin
                void'(q.pop_front());
                if (q.size() == 0) m_fcount = m_fcount + 16'd1;
            end
            nn  = enable ? n + 1 : 0;
            cap = enable && (nn >= FIRST_CAP) && (((nn - CAP_OFFSET) % FRAME_PERIOD) == 0);
            if (enable && !en_prev) m_overrun = 1'b0;
            if (cap) begin
                if (busy) begin
                    m_overrun = 1'b1;
                end else begin
                    for (int k = 0; k < NM; k++) begin
                        q.push_back(mic_left[k*DW +: DW]);
                        q.push_back(mic_right[k*DW +: DW]);
                    end
                end
            end
            n       = nn;
            en_prev = enable;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        logic [31:0] exp_data;
        logic        exp_last;
        exp_data = (q.size() > 0) ? q[0] : 32'd0;
        exp_last = (q.size() == 1);
        checkOutput("model_sck", 32'(sck), 32'((n / SD) % 2));
        checkOutput("model_ws", 32'(ws), 32'((n / (2 * SD * SB)) % 2));
        checkOutput("model_tvalid", 32'(tvalid), 32'(q.size() > 0));
        checkOutput("model_tdata", tdata, exp_data);
        checkOutput("model_tlast", 32'(tlast), 32'(exp_last));
        checkOutput("model_overrun", 32'(overrun), 32'(m_overrun));
        checkOutput("model_frame_count", 32'(frame_count), 32'(m_fcount));
    endtask

    task automatic applyStimulus(input logic en, input logic tr);
        enable = en;
        tready = tr;
        @(posedge clk);
        modelEdge();
        #1;
        checkModel();
    endtask

    task automatic waitValid(input int bound, input logic tr, output int cycles);
        cycles = 0;
        while (tvalid !== 1'b1 && cycles < bound) begin
            applyStimulus(enable, tr);
            cycles++;
        end
        if (tvalid !== 1'b1) checkOutput("wait_tvalid_timeout", 32'(tvalid), 32'd1);
    endtask

    task automatic runVectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            checkOutput($sformatf("vec%0d_tvalid", i), 32'(tvalid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_tdata", i), tdata, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_tlast", i), 32'(tlast), 32'(vecs[i].exp_last));
            applyStimulus(1'b1, vecs[i].tready);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        compared   = 0;
        mismatched = 0;

        exp_frame[0] = 32'hA0000001;
        exp_frame[1] = 32'hA0000002;
        exp_frame[2] = 32'hB0000001;
        exp_frame[3] = 32'hB0000002;

        vecs[0]  = '{1'b1, 1'b1, 32'hA0000001, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'hA0000002, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'hB0000001, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'hB0000002, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'hA0000001, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 32'hA0000001, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'hA0000002, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'hA0000002, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'hB0000001, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'hB0000001, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'hB0000002, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 32'hB0000002, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 32'h00000000, 1'b0};

        rst_n     = 1'b0;
        enable    = 1'b0;
        tready    = 1'b0;
        mic_left  = {32'hB0000001, 32'hA0000001};
        mic_right = {32'hB0000002, 32'hA0000002};
        modelReset();
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("reset_sck", 32'(sck), 32'd0);
        checkOutput("reset_ws", 32'(ws), 32'd0);
        checkOutput("reset_tvalid", 32'(tvalid), 32'd0);
        checkOutput("reset_tlast", 32'(tlast), 32'd0);
        checkOutput("reset_tdata", tdata, 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        checkOutput("reset_frame_count", 32'(frame_count), 32'd0);
        rst_n = 1'b1;

        $display("[TB] clock generation and basic frame");
        applyStimulus(1'b1, 1'b1);
        checkOutput("first_edge_sck_low", 32'(sck), 32'd0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("first_sck_rise", 32'(sck), 32'd1);
        waitValid(600, 1'b1, cyc);
        checkOutput("first_capture_latency", 32'(cyc + 2), 32'(FIRST_CAP));
        runVectors(0, 4);
        checkOutput("basic_frame_count", 32'(frame_count), 32'd1);

        $display("[TB] backpressure");
        waitValid(600, 1'b1, cyc);
        runVectors(5, 13);
        checkOutput("bp_frame_count", 32'(frame_count), 32'd2);

        $display("[TB] overrun");
        waitValid(600, 1'b1, cyc);
        mic_left  = {32'hD0000001, 32'hC0000001};
        mic_right = {32'hD0000002, 32'hC0000002};
        repeat (300) applyStimulus(1'b1, 1'b0);
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        checkOutput("overrun_fc_hold", 32'(frame_count), 32'd2);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("overrun_word%0d", i), tdata, exp_frame[i]);
            applyStimulus(1'b1, 1'b1);
        end
        checkOutput("overrun_frame_count", 32'(frame_count), 32'd3);
        checkOutput("overrun_tvalid_drop", 32'(tvalid), 32'd0);

        $display("[TB] disable mid-frame");
        waitValid(600, 1'b1, cyc);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("disable_sck", 32'(sck), 32'd0);
        checkOutput("disable_ws", 32'(ws), 32'd0);
        checkOutput("disable_tvalid_held", 32'(tvalid), 32'd1);
        checkOutput("disable_tdata", tdata, 32'hD0000002);
        checkOutput("disable_tlast", 32'(tlast), 32'd1);
        repeat (300) applyStimulus(1'b0, 1'b1);
        checkOutput("disable_frame_count", 32'(frame_count), 32'd4);
        checkOutput("disable_no_frames", 32'(tvalid), 32'd0);
        checkOutput("disable_overrun_sticky", 32'(overrun), 32'd1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reenable_overrun_clear", 32'(overrun), 32'd0);
        checkOutput("reenable_ws_low", 32'(ws), 32'd0);
        waitValid(600, 1'b1, cyc);
        checkOutput("reenable_capture_latency", 32'(cyc + 1), 32'(FIRST_CAP));

        $display("[TB] async reset mid-frame");
        repeat (260) applyStimulus(1'b1, 1'b0);
        checkOutput("pre_reset_overrun", 32'(overrun), 32'd1);
        applyStimulus(1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_tvalid", 32'(tvalid), 32'd0);
        checkOutput("async_reset_sck", 32'(sck), 32'd0);
        checkOutput("async_reset_ws", 32'(ws), 32'd0);
        checkOutput("async_reset_overrun", 32'(overrun), 32'd0);
        checkOutput("async_reset_frame_count", 32'(frame_count), 32'd0);
        modelReset();
        applyStimulus(1'b1, 1'b1);
        rst_n = 1'b1;
        waitValid(600, 1'b1, cyc);
        checkOutput("post_reset_capture_latency", 32'(cyc), 32'(FIRST_CAP));

        $display("[TB] randomized run");
        for (int c = 0; c < 4000; c++) begin
            logic en;
            logic tr;
            mic_left  = {$urandom, $urandom};
            mic_right = {$urandom, $urandom};
            en = ((c % 1300) < 1250);
            tr = ((c % 900) < 280) ? 1'b0 : ($urandom_range(0, 3) != 0);
            applyStimulus(en, tr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
